dm_arbiter: RTL and testbench

Arbitrates the single-ported data memory (dm, 1024 words, synchronous write, combinational read) between the pipeline MEM stage and a burst DMA port. Sits between the MEM stage and dm: the MEM stage drives its access request and receives read data and a stall, and the DMA engine performs multi-word read or write bursts through a request/acknowledge handshake. The CPU normally has priority. An optional anti-starvation counter forces DMA beats through by stalling the pipeline.

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_arb_starve_ctr.sv | 32 +++
 rtl/dm_arbiter.sv | 114 +++++++++++
 tb/tb_dm_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared constants and types for the data-memory arbiter between the MEM stage and the burst DMA port.
// The optional anti-starvation logic is enabled with the DM_ARB_STARVE_EN macro.
package dm_arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam int ADDR_W_DEF       = 10;
   localparam int LEN_W            = 5;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int STARVE_W         = 4;

   typedef logic [0:0]       arb_state_t;
   typedef logic [LEN_W-1:0] beat_cnt_t;

   function automatic logic is_last_beat(input beat_cnt_t idx, input beat_cnt_t len);
      return idx == (len - beat_cnt_t'(1));
   endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating count of DMA cycles lost to the CPU; raises forced once the limit is reached.
// Only instantiated when DM_ARB_STARVE_EN is defined.
module dm_arb_starve_ctr
   import dm_arb_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic forced
);

   logic [STARVE_W-1:0] cnt;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
      return (v >= STARVE_W'(LIMIT)) ? STARVE_W'(LIMIT) : v + STARVE_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= sat_inc(cnt);
   end

   assign forced = (cnt == STARVE_W'(LIMIT));

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-ported data memory between the MEM stage and a burst DMA engine.
// DM_ARB_STARVE_EN adds a forced DMA grant after STARVE_LIMIT lost cycles; otherwise the CPU has strict priority.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_mem_en,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [LEN_W-1:0]  dma_len,
   output logic              dma_ack,
   output logic              dma_busy,
   output logic              dma_beat,
   input  logic [31:0]       dma_wdata,
   output logic [31:0]       dma_rdata,
   output logic              dma_done,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   input  logic [31:0]       dm_dout
);

   arb_state_t        state;
   logic [ADDR_W-1:0] base;
   beat_cnt_t         len_q;
   logic              we_q;
   beat_cnt_t         idx;

   logic              in_burst;
   logic              accept;
   logic              forced;
   logic              dma_win;
   logic              last_beat;
   logic [ADDR_W-1:0] beat_addr;
   logic [ADDR_W-1:0] cpu_word;
   logic              unused_cpu_addr;

   assign cpu_word        = cpu_addr[ADDR_W+1:2];
   assign unused_cpu_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

   // Reset gates every combinational handshake and the memory write strobe.
   assign in_burst  = (state == ST_BURST) & ~reset;
   assign accept    = (state == ST_IDLE) & ~reset & dma_req & (dma_len != '0);
   assign dma_win   = in_burst & (~cpu_mem_en | forced);
   assign last_beat = is_last_beat(idx, len_q);
   assign beat_addr = base + ADDR_W'(idx);

`ifdef DM_ARB_STARVE_EN
   logic cpu_win;

   assign cpu_win = in_burst & cpu_mem_en & ~forced;

   dm_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept | dma_win),
      .inc    (cpu_win),
      .forced (forced)
   );

   assign cpu_stall = dma_win & cpu_mem_en;
`else
   assign forced    = 1'b0;
   assign cpu_stall = 1'b0;
`endif

   assign dma_ack   = accept;
   assign dma_busy  = (state == ST_BURST);
   assign dma_beat  = dma_win;
   assign dma_done  = dma_win & last_beat;

   // A DMA win takes the whole port; a stalled CPU access is simply dropped.
   assign dm_addr   = dma_win ? beat_addr : cpu_word;
   assign dm_din    = dma_win ? dma_wdata : cpu_wdata;
   assign dm_we     = ~reset & (dma_win ? we_q : (cpu_mem_en & cpu_we));
   assign cpu_rdata = dm_dout;
   assign dma_rdata = dm_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else if (accept) begin
         state <= ST_BURST;
         idx   <= '0;
      end else if (dma_win) begin
         idx <= idx + beat_cnt_t'(1);
         if (last_beat)
            state <= ST_IDLE;
      end
   end

   // Burst descriptor is data, captured only on acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         base  <= dma_addr;
         len_q <= dma_len;
         we_q  <= dma_we;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 1024-word data memory.
// Forced-grant expectations follow DM_ARB_STARVE_EN; the default build checks strict CPU priority.
module tb_dm_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_mem_en;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        dma_req;
   logic        dma_we;
   logic [9:0]  dma_addr;
   logic [4:0]  dma_len;
   logic        dma_ack;
   logic        dma_busy;
   logic        dma_beat;
   logic [31:0] dma_wdata;
   logic [31:0] dma_rdata;
   logic        dma_done;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic        dm_we;
   logic [31:0] dm_dout;

   logic        mem_init;
   logic [31:0] mem [0:1023];

   int errors = 0;
   int checks = 0;

   logic [9:0] wrap_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

   dm_arbiter #(
      .ADDR_W       (10),
      .STARVE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_mem_en (cpu_mem_en),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_len    (dma_len),
      .dma_ack    (dma_ack),
      .dma_busy   (dma_busy),
      .dma_beat   (dma_beat),
      .dma_wdata  (dma_wdata),
      .dma_rdata  (dma_rdata),
      .dma_done   (dma_done),
      .dm_addr    (dm_addr),
      .dm_din     (dm_din),
      .dm_we      (dm_we),
      .dm_dout    (dm_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_dout = mem[dm_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++)
            mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (dm_we) begin
         mem[dm_addr] <= dm_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      mem_init   = 1'b1;
      reset      = 1'b1;
      cpu_mem_en = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      dma_req    = 1'b0;
      dma_we     = 1'b0;
      dma_addr   = '0;
      dma_len    = '0;
      dma_wdata  = '0;
      tick();
      tick();
      mem_init = 1'b0;

      // reset state with live requests on both ports
      cpu_mem_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; dma_req = 1'b1; dma_len = 5'd3;
      #1;
      chk("rst dm_we", dm_we, 0);
      chk("rst ack", dma_ack, 0);
      chk("rst busy", dma_busy, 0);
      chk("rst beat", dma_beat, 0);
      chk("rst done", dma_done, 0);
      chk("rst stall", cpu_stall, 0);
      tick();
      reset = 1'b0; cpu_mem_en = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
      #1;
      chk("post-rst busy", dma_busy, 0);
      chk("post-rst mem32 untouched", mem[32], 32'h1000_0020);

      // wrapping write burst, request held high throughout
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h3FE; dma_len = 5'd4;
      #1;
      chk("A ack", dma_ack, 1);
      chk("A busy before", dma_busy, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         dma_wdata = 32'hA0 + 32'(k);
         #1;
         chk("A beat", dma_beat, 1);
         chk("A addr", dm_addr, wrap_addr[k]);
         chk("A dm_we", dm_we, 1);
         chk("A din", dm_din, 32'hA0 + 32'(k));
         chk("A done", dma_done, (k == 3));
         chk("A ack ignored", dma_ack, 0);
         chk("A busy", dma_busy, 1);
         tick();
      end
      dma_req = 1'b0;
      #1;
      chk("A busy after", dma_busy, 0);
      chk("A ack after", dma_ack, 0);
      cpu_mem_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFC;
      #1;
      chk("A readback 3FF", cpu_rdata, 32'hA1);
      cpu_addr = 32'h4;
      #1;
      chk("A readback 001", cpu_rdata, 32'hA3);
      tick();

      // read burst of len 2 from 0x3FE against a saturating CPU
      cpu_mem_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h3FE; dma_len = 5'd2;
      #1;
      chk("B ack", dma_ack, 1);
      chk("B idle stall", cpu_stall, 0);
      chk("B cpu read", cpu_rdata, 32'h1000_0008);
      tick();
      dma_req = 1'b0;
`ifdef DM_ARB_STARVE_EN
      for (int c = 1; c <= 10; c++) begin
         #1;
         chk("B beat", dma_beat, (c == 5 || c == 10));
         chk("B stall", cpu_stall, (c == 5 || c == 10));
         chk("B done", dma_done, (c == 10));
         if (c == 5)
            chk("B rdata0", dma_rdata, 32'hA0);
         else if (c == 10)
            chk("B rdata1", dma_rdata, 32'hA1);
         else
            chk("B cpu addr", dm_addr, 10'd8);
         tick();
      end
`else
      for (int c = 1; c <= 10; c++) begin
         #1;
         chk("B strict beat", dma_beat, 0);
         chk("B strict stall", cpu_stall, 0);
         chk("B strict addr", dm_addr, 10'd8);
         chk("B strict busy", dma_busy, 1);
         tick();
      end
      cpu_mem_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("B strict late beat", dma_beat, 1);
         chk("B strict rdata", dma_rdata, 32'hA0 + 32'(k));
         chk("B strict done", dma_done, (k == 1));
         chk("B strict stall idle", cpu_stall, 0);
         tick();
      end
`endif
      #1;
      chk("B busy after", dma_busy, 0);
      cpu_mem_en = 1'b0;

      // zero-length request is ignored, CPU store proceeds
      cpu_mem_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h55AA_33CC;
      dma_req = 1'b1; dma_len = 5'd0;
      #1;
      chk("C ack", dma_ack, 0);
      chk("C dm_we", dm_we, 1);
      chk("C addr", dm_addr, 10'd16);
      tick();
      cpu_we = 1'b0;
      #1;
      chk("C busy", dma_busy, 0);
      chk("C ack held", dma_ack, 0);
      chk("C readback", cpu_rdata, 32'h55AA_33CC);
      tick();
      dma_req = 1'b0; cpu_mem_en = 1'b0;

      // collision on word 4: CPU store first, DMA beat on the next idle cycle
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'd4; dma_len = 5'd1;
      #1;
      chk("D ack", dma_ack, 1);
      tick();
      dma_req = 1'b0;
      cpu_mem_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
      dma_wdata = 32'h1234_5678;
      #1;
      chk("D cpu wins beat", dma_beat, 0);
      chk("D cpu wins stall", cpu_stall, 0);
      chk("D cpu addr", dm_addr, 10'd4);
      chk("D cpu din", dm_din, 32'hDEAD_BEEF);
      tick();
      cpu_mem_en = 1'b0; cpu_we = 1'b0;
      #1;
      chk("D cpu first", mem[4], 32'hDEAD_BEEF);
      chk("D beat", dma_beat, 1);
      chk("D done", dma_done, 1);
      chk("D din", dm_din, 32'h1234_5678);
      tick();
      chk("D overwrite", mem[4], 32'h1234_5678);
      chk("D busy after", dma_busy, 0);

      // reset after two of eight write beats
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h100; dma_len = 5'd8;
      #1;
      chk("E ack", dma_ack, 1);
      tick();
      dma_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         dma_wdata = 32'hB0 + 32'(k);
         #1;
         chk("E beat", dma_beat, 1);
         tick();
      end
      reset = 1'b1; dma_wdata = 32'hB2;
      #1;
      chk("E rst dm_we", dm_we, 0);
      chk("E rst beat", dma_beat, 0);
      chk("E rst done", dma_done, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("E busy", dma_busy, 0);
      chk("E no done", dma_done, 0);
      chk("E no beat", dma_beat, 0);
      chk("E word0", mem[10'h100], 32'hB0);
      chk("E word1", mem[10'h101], 32'hB1);
      for (int i = 2; i < 8; i++)
         chk("E untouched", mem[10'h100 + 10'(i)], 32'h1000_0100 + 32'(i));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
